// File: rtl/botupdt_sync_multi.sv
// Multi-channel Rojobot update/acknowledge handshake: per-channel strobe sync,
// sticky pending flag, info snapshot, missed-update counter and a prioritised IRQ.

module botupdt_ch #(
    parameter int SYNC_STAGES = 2,
    parameter int INFO_W      = 32,
    parameter int OVF_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              upd,
    input  logic [INFO_W-1:0] info,
    input  logic              ack,
    input  logic              miss_clr,
    output logic              pending,
    output logic [INFO_W-1:0] info_q,
    output logic [OVF_W-1:0]  miss_cnt
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev;
    logic                   evt;
    logic                   ovwr;

    assign evt  = sync_q[SYNC_STAGES-1] & ~prev;
    // An event while still pending replaces an unread snapshot, unless the CPU is acking it now.
    assign ovwr = evt & pending & ~ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            prev     <= 1'b0;
            pending  <= 1'b0;
            info_q   <= '0;
            miss_cnt <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], upd};
            prev   <= sync_q[SYNC_STAGES-1];
            if (evt) begin
                pending <= 1'b1;
                info_q  <= info;
            end else if (ack) begin
                pending <= 1'b0;
            end
            if (miss_clr)
                miss_cnt <= ovwr ? OVF_W'(1) : '0;
            else if (ovwr && miss_cnt != '1)
                miss_cnt <= miss_cnt + 1'b1;
        end
    end
endmodule

module botupdt_sync_multi #(
    parameter int NUM_CH      = 2,
    parameter int SYNC_STAGES = 2,
    parameter int INFO_W      = 32,
    parameter int OVF_W       = 8,
    parameter int ID_W        = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        i_upd,
    input  logic [NUM_CH*INFO_W-1:0] i_info,
    input  logic [NUM_CH-1:0]        i_ack,
    input  logic [NUM_CH-1:0]        i_mask,
    input  logic [NUM_CH-1:0]        i_miss_clr,
    output logic [NUM_CH-1:0]        o_pending,
    output logic [NUM_CH*INFO_W-1:0] o_info,
    output logic [NUM_CH*OVF_W-1:0]  o_miss_cnt,
    output logic                     o_irq,
    output logic [ID_W-1:0]          o_irq_id
);
    logic [NUM_CH-1:0] active;
    logic [ID_W-1:0]   id_nxt;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        botupdt_ch #(
            .SYNC_STAGES(SYNC_STAGES),
            .INFO_W     (INFO_W),
            .OVF_W      (OVF_W)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .upd     (i_upd[g]),
            .info    (i_info[g*INFO_W +: INFO_W]),
            .ack     (i_ack[g]),
            .miss_clr(i_miss_clr[g]),
            .pending (o_pending[g]),
            .info_q  (o_info[g*INFO_W +: INFO_W]),
            .miss_cnt(o_miss_cnt[g*OVF_W +: OVF_W])
        );
    end

    // Scan downward so the lowest unmasked pending channel wins.
    always_comb begin
        active = o_pending & ~i_mask;
        id_nxt = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (active[i]) id_nxt = ID_W'(i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_irq    <= 1'b0;
            o_irq_id <= '0;
        end else begin
            o_irq    <= |active;
            o_irq_id <= id_nxt;
        end
    end
endmodule

// File: tb/tb_botupdt_sync_multi.sv
// Directed bench for botupdt_sync_multi (2 channels): vector table plus hand-written sequences.

module tb_botupdt_sync_multi;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  upd, ack, mask, clr;
    logic [31:0] info0, info1;
    logic [63:0] i_info;
    logic [1:0]  pending;
    logic [63:0] o_info;
    logic [15:0] miss;
    logic        irq;
    logic [2:0]  irq_id;

    int checks = 0;
    int errors = 0;

    assign i_info = {info1, info0};

    always #5 clk = ~clk;

    botupdt_sync_multi #(
        .NUM_CH(2), .SYNC_STAGES(2), .INFO_W(32), .OVF_W(8), .ID_W(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_upd     (upd),
        .i_info    (i_info),
        .i_ack     (ack),
        .i_mask    (mask),
        .i_miss_clr(clr),
        .o_pending (pending),
        .o_info    (o_info),
        .o_miss_cnt(miss),
        .o_irq     (irq),
        .o_irq_id  (irq_id)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise upd for two edges, then low for two: pending/info captured on the third edge.
    task automatic pulse(input logic [1:0] ch);
        upd = ch;
        step();
        step();
        upd = 2'b00;
        step();
        step();
    endtask

    typedef struct {
        logic        rst;
        logic [1:0]  upd;
        logic [1:0]  ack;
        logic [31:0] info0;
        logic [1:0]  ep;
        logic        eirq;
        logic [2:0]  eid;
        logic [31:0] einfo0;
    } vec_t;

    vec_t vt[8];

    initial begin
        vt[0] = '{1'b1, 2'b00, 2'b00, 32'h0,         2'b00, 1'b0, 3'd0, 32'h0};
        vt[1] = '{1'b0, 2'b01, 2'b00, 32'h1234_5678, 2'b00, 1'b0, 3'd0, 32'h0};
        vt[2] = '{1'b0, 2'b01, 2'b00, 32'h1234_5678, 2'b00, 1'b0, 3'd0, 32'h0};
        vt[3] = '{1'b0, 2'b01, 2'b00, 32'h1234_5678, 2'b01, 1'b0, 3'd0, 32'h1234_5678};
        vt[4] = '{1'b0, 2'b01, 2'b00, 32'h1234_5678, 2'b01, 1'b1, 3'd0, 32'h1234_5678};
        vt[5] = '{1'b0, 2'b00, 2'b00, 32'h1234_5678, 2'b01, 1'b1, 3'd0, 32'h1234_5678};
        vt[6] = '{1'b0, 2'b00, 2'b01, 32'h1234_5678, 2'b00, 1'b1, 3'd0, 32'h1234_5678};
        vt[7] = '{1'b0, 2'b00, 2'b00, 32'h1234_5678, 2'b00, 1'b0, 3'd0, 32'h1234_5678};

        rst = 1'b1; upd = '0; ack = '0; mask = '0; clr = '0; info0 = '0; info1 = '0;
        step();

        for (int i = 0; i < 8; i++) begin
            rst   = vt[i].rst;
            upd   = vt[i].upd;
            ack   = vt[i].ack;
            info0 = vt[i].info0;
            step();
            chk($sformatf("vec%0d pending", i), 32'(pending), 32'(vt[i].ep));
            chk($sformatf("vec%0d irq", i),     32'(irq),     32'(vt[i].eirq));
            chk($sformatf("vec%0d irq_id", i),  32'(irq_id),  32'(vt[i].eid));
            chk($sformatf("vec%0d info0", i),   o_info[31:0], vt[i].einfo0);
            if (i == 0) chk("reset miss", 32'(miss), 32'h0);
        end
        ack = '0;

        // Overwrite and saturation on channel 1
        info1 = 32'hA;
        pulse(2'b10);
        chk("ov first pending", 32'(pending), 32'h2);
        chk("ov first info1", o_info[63:32], 32'hA);
        chk("ov first miss1", 32'(miss[15:8]), 32'h0);
        chk("ov irq", 32'(irq), 32'h1);
        chk("ov irq_id", 32'(irq_id), 32'h1);
        info1 = 32'hB;
        pulse(2'b10);
        chk("ov second miss1", 32'(miss[15:8]), 32'h1);
        chk("ov second info1", o_info[63:32], 32'hB);
        chk("ov second pending", 32'(pending), 32'h2);
        for (int i = 0; i < 300; i++) begin
            info1 = 32'h100 + i;
            pulse(2'b10);
        end
        chk("sat miss1", 32'(miss[15:8]), 32'hFF);
        chk("sat info1", o_info[63:32], 32'h100 + 299);
        chk("sat miss0", 32'(miss[7:0]), 32'h0);
        clr = 2'b10;
        step();
        clr = 2'b00;
        chk("clr miss1", 32'(miss[15:8]), 32'h0);
        chk("clr pending", 32'(pending), 32'h2);

        // Ack coinciding with an event on a pending channel
        info0 = 32'hC0;
        pulse(2'b01);
        chk("col pre pending", 32'(pending), 32'h3);
        info0 = 32'hC1;
        upd = 2'b01;
        step();
        step();
        upd = 2'b00;
        ack = 2'b01;
        step();
        ack = 2'b00;
        chk("col pending", 32'(pending), 32'h3);
        chk("col miss0", 32'(miss[7:0]), 32'h0);
        chk("col info0", o_info[31:0], 32'hC1);
        step();
        chk("prio irq", 32'(irq), 32'h1);
        chk("prio irq_id", 32'(irq_id), 32'h0);

        // Mask
        mask = 2'b01;
        step();
        chk("mask01 irq", 32'(irq), 32'h1);
        chk("mask01 irq_id", 32'(irq_id), 32'h1);
        mask = 2'b11;
        step();
        chk("mask11 irq", 32'(irq), 32'h0);
        chk("mask11 irq_id", 32'(irq_id), 32'h0);
        chk("mask11 pending", 32'(pending), 32'h3);
        mask = 2'b00;

        // Reset mid-operation
        info1 = 32'hD1;
        pulse(2'b10);
        chk("prerst miss1", 32'(miss[15:8]), 32'h1);
        rst = 1'b1;
        step();
        chk("rst pending", 32'(pending), 32'h0);
        chk("rst info", o_info[31:0] | o_info[63:32], 32'h0);
        chk("rst miss", 32'(miss), 32'h0);
        chk("rst irq", 32'(irq), 32'h0);
        chk("rst irq_id", 32'(irq_id), 32'h0);

        // Strobe held high through reset
        upd = 2'b01;
        info0 = 32'hE0;
        step();
        rst = 1'b0;
        step();
        step();
        chk("hold edge2 pending", 32'(pending), 32'h0);
        step();
        chk("hold edge3 pending", 32'(pending), 32'h1);
        chk("hold info0", o_info[31:0], 32'hE0);
        for (int i = 0; i < 6; i++) step();
        chk("hold miss0", 32'(miss[7:0]), 32'h0);
        ack = 2'b01;
        step();
        ack = 2'b00;
        for (int i = 0; i < 6; i++) step();
        chk("hold no re-event", 32'(pending), 32'h0);
        chk("hold irq low", 32'(irq), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/botupdt_sync_multi.md
Name: botupdt_sync_multi

Overview:
- Multi-channel successor to the single Rojobot update/acknowledge handshake flip-flop.
- For each of NUM_CH bot channels it:
  - synchronises the update strobe;
  - detects its rising edge;
  - holds a sticky pending flag until the CPU acknowledges it;
  - captures a snapshot of that channel's bot-info word;
  - counts updates that were overwritten before acknowledge.
- Drives one maskable, prioritised interrupt to the core GPIO/interrupt logic.

Parameters:
- NUM_CH, 2, number of bot channels (1..8).
- SYNC_STAGES, 2, flops in each update-strobe synchroniser (>=2).
- INFO_W, 32, bot-info word width per channel ({LocX, LocY, Sensors, BotInfo}).
- OVF_W, 8, width of each per-channel missed-update counter.
- ID_W, 3, width of o_irq_id. Must be >= $clog2(NUM_CH), minimum 1.

Ports:
- clk  input  1  system clock; all flops on rising edge.
- rst  input  1  synchronous, active-high reset.
- i_upd  input  NUM_CH  update strobes from the bot clock domain (asynchronous to clk), one bit per channel.
- i_info  input  NUM_CH*INFO_W  bot-info words; channel n occupies bits [n*INFO_W +: INFO_W].
- i_ack  input  NUM_CH  CPU acknowledge, one bit per channel; one-cycle pulse or level.
- i_mask  input  NUM_CH  1 = channel excluded from o_irq.
- i_miss_clr  input  NUM_CH  clears that channel's missed-update counter.
- o_pending  output  NUM_CH  sticky per-channel update-pending flags.
- o_info  output  NUM_CH*INFO_W  per-channel info snapshot, captured on each detected update.
- o_miss_cnt  output  NUM_CH*OVF_W  per-channel saturating count of overwritten updates.
- o_irq  output  1  registered OR of unmasked pending channels.
- o_irq_id  output  ID_W  lowest-index unmasked pending channel; 0 when o_irq=0.

Behaviour:
- Reset (rst=1 at a clk edge): every synchroniser flop, edge-detect flop, o_pending, o_info, o_miss_cnt, o_irq and o_irq_id go to 0.
  - While rst=1, all other inputs are ignored.
  - Reset mid-operation discards all pending events and snapshots.
- Synchroniser: i_upd[n] passes through SYNC_STAGES flops to give s[n]. Edge-detect flop p[n] <= s[n]. Event e[n] = s[n] & ~p[n].
  - Latency: i_upd rise sampled at edge k -> e[n] high during the cycle after edge k+SYNC_STAGES-1.
  - o_pending[n] is set at the next edge, i.e. visible SYNC_STAGES+1 edges after sampling.
  - An i_upd held high through reset produces exactly one event after reset release.
  - Strobes shorter than one clk period are not guaranteed to be detected. The bot domain holds upd >= 2 clk periods.
- Per-channel pending/snapshot/miss update on each clk edge, evaluated together:
  - e=1, pending=0: pending<=1; o_info[n]<=i_info[n]; miss unchanged.
  - e=1, pending=1, ack=0: pending stays 1; o_info overwritten with the new info; miss<=miss+1, saturating at 2^OVF_W-1.
  - e=1, ack=1: pending stays 1 (new event wins); o_info overwritten; miss unchanged.
  - e=0, ack=1: pending<=0; o_info holds.
  - ack while pending=0 and e=0: no effect.
  - i_miss_clr=1: miss<=0. If an overwrite increment occurs in the same cycle, miss<=1.
- Snapshot capture samples i_info in the same cycle as e[n].
  - i_info is stable from before upd rises until after it falls (bot-domain guarantee).
  - The synchroniser delay therefore ensures a clean capture.
- Interrupt logic (registered from the current o_pending):
  - o_irq <= |(o_pending & ~i_mask).
  - o_irq_id <= index of the lowest set bit of (o_pending & ~i_mask), or 0 if none.
  - o_irq therefore asserts one cycle after o_pending.
  - o_irq drops one cycle after the last unmasked pending bit clears or becomes masked.
- Masking affects only o_irq/o_irq_id. Masked channels still set pending, capture info and count misses.
- Channels are fully independent. Simultaneous events on several channels are all recorded in the same cycle.

Test Plan (NUM_CH=2, SYNC_STAGES=2, INFO_W=32, OVF_W=8):
- Single update:
  - Stimulus: i_info[0]=32'h1234_5678, pulse i_upd[0] high for 4 cycles.
  - Response: o_pending=2'b01 three edges after the first sample; o_info[0]=32'h12345678; o_irq=1 and o_irq_id=0 one cycle later.
  - Then pulse i_ack[0]: o_pending=0, o_irq=0 one cycle after that.
- Overwrite:
  - Stimulus: with ch1 pending (info 32'hA), a second update on ch1 with info 32'hB, no ack.
  - Response: o_miss_cnt[1]=1; o_info[1]=32'hB; pending stays 1.
  - 300 further updates without ack: counter saturates at 8'hFF.
  - i_miss_clr[1]: counter reads 0.
- Ack/event collision: assert i_ack[0] in the exact cycle of e[0] while ch0 is pending -> pending stays 1, miss unchanged, o_info updated.
- Priority and mask:
  - Both channels pending: o_irq_id=0.
  - Set i_mask=2'b01: next cycle o_irq_id=1, o_irq=1.
  - Set i_mask=2'b11: o_irq=0, o_irq_id=0, o_pending still 2'b11.
- Reset cases:
  - Reset mid-operation with both channels pending and miss counts nonzero -> all outputs 0 the edge after rst.
  - i_upd[0] held high through reset -> exactly one event, o_pending[0]=1 at SYNC_STAGES+1 edges after rst deasserts.
